// File: rtl/rv32i_lsu_byteseq.sv
// Byte-serial load/store sequencer between the RV32I execute stage and a byte-wide data RAM.
// Optional macro LSU_MISALIGN_TRAP_EN turns misaligned halfword/word requests into errors.
module rv32i_lsu_byteseq #(
    parameter int AWIDTH = 12
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic [2:0]        req_funct3,
    input  logic [31:0]       req_addr,
    input  logic [31:0]       req_wdata,
    output logic              resp_valid,
    output logic              resp_err,
    output logic [31:0]       resp_rdata,
    output logic [AWIDTH-1:0] ram_address,
    output logic [7:0]        ram_data,
    output logic              ram_wren,
    input  logic [7:0]        ram_q
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ACCESS  = 2'd1,
        ST_CAPTURE = 2'd2,
        ST_RESP    = 2'd3
    } state_t;

    localparam logic [32:0] ADDR_MAX = (33'd1 << AWIDTH) - 33'd1;

    state_t            state_r;
    logic [2:0]        funct3_r;
    logic              we_r;
    logic [AWIDTH-1:0] addr_r;
    logic [3:0][7:0]   wdata_r;
    logic [3:0][7:0]   bytes_r;
    logic [1:0]        k_r;
    logic [1:0]        last_r;

    logic [1:0]        last_s;
    logic [32:0]       end_addr_s;
    logic              bad_f3_s;
    logic              range_err_s;
    logic              misalign_s;
    logic              err_s;
    logic [1:0]        next_k_s;
    logic [1:0]        prev_k_s;
    logic [3:0][7:0]   full_s;

    // Sign/zero extension of the assembled little-endian bytes by load opcode.
    function automatic logic [31:0] load_extend(input logic [2:0] f3, input logic [3:0][7:0] b);
        logic [31:0] r;
        case (f3)
            3'd0:    r = {{24{b[0][7]}}, b[0]};
            3'd1:    r = {{16{b[1][7]}}, b[1], b[0]};
            3'd2:    r = {b[3], b[2], b[1], b[0]};
            3'd4:    r = {24'd0, b[0]};
            3'd5:    r = {16'd0, b[1], b[0]};
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    assign req_ready = (state_r == ST_IDLE);

    // Request decode: byte count, legality and range checks on the live request.
    always_comb begin
        last_s = 2'd0;
        case (req_funct3[1:0])
            2'd0:    last_s = 2'd0;
            2'd1:    last_s = 2'd1;
            2'd2:    last_s = 2'd3;
            default: last_s = 2'd0;
        endcase
        bad_f3_s    = (req_funct3 == 3'd3) || (req_funct3 == 3'd6) || (req_funct3 == 3'd7) ||
                      (req_we && ((req_funct3 == 3'd4) || (req_funct3 == 3'd5)));
        end_addr_s  = {1'b0, req_addr} + {31'd0, last_s};
        range_err_s = (end_addr_s > ADDR_MAX);
`ifdef LSU_MISALIGN_TRAP_EN
        if (req_funct3[1:0] == 2'd1) begin
            misalign_s = req_addr[0];
        end else if (req_funct3[1:0] == 2'd2) begin
            misalign_s = (req_addr[1:0] != 2'd0);
        end else begin
            misalign_s = 1'b0;
        end
`else
        misalign_s = 1'b0;
`endif
        err_s = bad_f3_s || range_err_s || misalign_s;
    end

    // Byte index arithmetic and final load word including the byte arriving this cycle.
    always_comb begin
        next_k_s = k_r + 2'd1;
        prev_k_s = k_r - 2'd1;
        full_s   = bytes_r;
        if (state_r == ST_CAPTURE) begin
            full_s[last_r] = ram_q;
        end else begin
            full_s = bytes_r;
        end
    end

    // Sequencer FSM with registered RAM and response outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_r     <= ST_IDLE;
            funct3_r    <= 3'd0;
            we_r        <= 1'b0;
            addr_r      <= '0;
            wdata_r     <= '0;
            bytes_r     <= '0;
            k_r         <= 2'd0;
            last_r      <= 2'd0;
            resp_valid  <= 1'b0;
            resp_err    <= 1'b0;
            resp_rdata  <= 32'd0;
            ram_address <= '0;
            ram_data    <= 8'd0;
            ram_wren    <= 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    if (req_valid) begin
                        funct3_r <= req_funct3;
                        we_r     <= req_we;
                        addr_r   <= req_addr[AWIDTH-1:0];
                        wdata_r  <= req_wdata;
                        last_r   <= last_s;
                        k_r      <= 2'd0;
                        bytes_r  <= '0;
                        if (err_s) begin
                            state_r    <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b1;
                            resp_rdata <= 32'd0;
                        end else begin
                            state_r     <= ST_ACCESS;
                            ram_address <= req_addr[AWIDTH-1:0];
                            ram_data    <= req_wdata[7:0];
                            ram_wren    <= req_we;
                        end
                    end
                end
                ST_ACCESS: begin
                    // The byte addressed in the previous ACCESS cycle is on ram_q now.
                    if ((k_r != 2'd0) && !we_r) begin
                        bytes_r[prev_k_s] <= ram_q;
                    end
                    if (k_r == last_r) begin
                        ram_wren <= 1'b0;
                        if (we_r) begin
                            state_r    <= ST_RESP;
                            resp_valid <= 1'b1;
                            resp_err   <= 1'b0;
                            resp_rdata <= 32'd0;
                        end else begin
                            state_r <= ST_CAPTURE;
                        end
                    end else begin
                        k_r         <= next_k_s;
                        ram_address <= addr_r + {{(AWIDTH-2){1'b0}}, next_k_s};
                        ram_data    <= wdata_r[next_k_s];
                    end
                end
                ST_CAPTURE: begin
                    state_r    <= ST_RESP;
                    resp_valid <= 1'b1;
                    resp_err   <= 1'b0;
                    resp_rdata <= load_extend(funct3_r, full_s);
                end
                ST_RESP: begin
                    state_r    <= ST_IDLE;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    resp_rdata <= 32'd0;
                end
                default: begin
                    state_r    <= ST_IDLE;
                    resp_valid <= 1'b0;
                    resp_err   <= 1'b0;
                    ram_wren   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rv32i_lsu_byteseq.sv
// Scoreboard bench for rv32i_lsu_byteseq with a behavioural byte RAM (registered read, write-first).
module tb_rv32i_lsu_byteseq;

    localparam int AW = 12;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [2:0]    req_funct3;
    logic [31:0]   req_addr;
    logic [31:0]   req_wdata;
    logic          resp_valid;
    logic          resp_err;
    logic [31:0]   resp_rdata;
    logic [AW-1:0] ram_address;
    logic [7:0]    ram_data;
    logic          ram_wren;
    logic [7:0]    ram_q = 8'd0;

    logic [7:0]    mem [0:(1<<AW)-1];
    logic          mem_clr = 1'b1;

    int cyc = 0;
    int errors = 0;
    int checks = 0;
    int wr_cnt = 0;
    int wr_snap = 0;

    typedef struct {
        int          cyc;
        logic        err;
        logic [31:0] rdata;
        string       name;
    } exp_t;

    exp_t sb_q[$];
    exp_t got_e;

    rv32i_lsu_byteseq #(.AWIDTH(AW)) dut (
        .clock(clock), .reset_n(reset_n),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_funct3(req_funct3), .req_addr(req_addr), .req_wdata(req_wdata),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
        .ram_address(ram_address), .ram_data(ram_data), .ram_wren(ram_wren),
        .ram_q(ram_q)
    );

    always #5 clock = ~clock;

    always @(posedge clock) cyc <= cyc + 1;

    always @(posedge clock) begin
        if (mem_clr) begin
            for (int i = 0; i < (1 << AW); i++) mem[i] <= 8'd0;
            ram_q <= 8'd0;
        end else begin
            if (ram_wren) mem[ram_address] <= ram_data;
            ram_q <= ram_wren ? ram_data : mem[ram_address];
        end
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h, required 0x%08h", nm, act, exp);
        end
    endtask

    // Monitor: pops the scoreboard on every response pulse.
    always @(negedge clock) begin
        if (ram_wren) wr_cnt++;
        if (resp_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_resp: resp_valid=1 at cycle %0d, required no response", cyc);
            end else begin
                got_e = sb_q.pop_front();
                chk({got_e.name, "_cycle"}, 32'(cyc), 32'(got_e.cyc));
                chk({got_e.name, "_err"}, {31'd0, resp_err}, {31'd0, got_e.err});
                chk({got_e.name, "_rdata"}, resp_rdata, got_e.rdata);
            end
        end
    end

    task automatic do_req(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                          input logic [31:0] wdata, input bit expect_resp, input logic err,
                          input logic [31:0] rdata, input int lat, input string nm);
        exp_t e;
        int n;
        n = 0;
        @(posedge clock); #1;
        while (!req_ready && n < 50) begin
            @(posedge clock); #1;
            n++;
        end
        chk({nm, "_ready"}, {31'd0, req_ready}, 32'd1);
        req_valid  = 1'b1;
        req_we     = we;
        req_funct3 = f3;
        req_addr   = addr;
        req_wdata  = wdata;
        if (expect_resp) begin
            e.cyc   = cyc + lat;
            e.err   = err;
            e.rdata = rdata;
            e.name  = nm;
            sb_q.push_back(e);
        end
        @(posedge clock); #1;
        req_valid  = 1'b0;
        req_we     = 1'($urandom);
        req_funct3 = 3'($urandom);
        req_addr   = $urandom;
        req_wdata  = $urandom;
    endtask

    task automatic wait_done(input string nm);
        for (int i = 0; i < 40 && sb_q.size() != 0; i++) @(posedge clock);
        if (sb_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: %0d responses outstanding, required 0", nm, sb_q.size());
            sb_q.delete();
        end
    endtask

    task automatic run(input logic we, input logic [2:0] f3, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic err, input logic [31:0] rdata,
                       input int lat, input string nm);
        do_req(we, f3, addr, wdata, 1'b1, err, rdata, lat, nm);
        wait_done(nm);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        req_valid  = 1'b0;
        req_we     = 1'b0;
        req_funct3 = 3'd0;
        req_addr   = 32'd0;
        req_wdata  = 32'd0;
        repeat (3) @(posedge clock);
        #1;
        chk("rst_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_resp", {30'd0, resp_valid, resp_err}, 32'd0);
        chk("rst_rdata", resp_rdata, 32'd0);
        chk("rst_ram", {11'd0, ram_wren, ram_data, ram_address}, 32'd0);
        mem_clr = 1'b0;
        #3 reset_n = 1'b1;

        // Word store then load-back
        run(1'b1, 3'd2, 32'h010, 32'hA1B2C3D4, 1'b0, 32'd0, 5, "sw_010");
        chk("sw_010_mem", {mem[12'h013], mem[12'h012], mem[12'h011], mem[12'h010]}, 32'hA1B2C3D4);
        run(1'b0, 3'd2, 32'h010, 32'd0, 1'b0, 32'hA1B2C3D4, 6, "lw_010");

        // Byte and halfword extension
        run(1'b1, 3'd0, 32'h7FF, 32'h00000080, 1'b0, 32'd0, 2, "sb_7ff");
        chk("sb_7ff_mem", {24'd0, mem[12'h7FF]}, 32'h80);
        run(1'b0, 3'd0, 32'h7FF, 32'd0, 1'b0, 32'hFFFFFF80, 3, "lb_7ff");
        run(1'b0, 3'd4, 32'h7FF, 32'd0, 1'b0, 32'h00000080, 3, "lbu_7ff");
        run(1'b1, 3'd1, 32'h020, 32'h12348001, 1'b0, 32'd0, 3, "sh_020");
        run(1'b0, 3'd1, 32'h020, 32'd0, 1'b0, 32'hFFFF8001, 4, "lh_020");
        run(1'b0, 3'd5, 32'h020, 32'd0, 1'b0, 32'h00008001, 4, "lhu_020");

        // Top-of-range boundaries
        run(1'b1, 3'd0, 32'hFFF, 32'hDEADBE5A, 1'b0, 32'd0, 2, "sb_fff");
        run(1'b0, 3'd4, 32'hFFF, 32'd0, 1'b0, 32'h0000005A, 3, "lbu_fff");
        run(1'b0, 3'd2, 32'hFFC, 32'd0, 1'b0, 32'h5A000000, 6, "lw_ffc");

        // Errors: range and illegal funct3, no RAM writes allowed
        wr_snap = wr_cnt;
        run(1'b0, 3'd2, 32'hFFE, 32'd0, 1'b1, 32'd0, 1, "lw_ffe_err");
        run(1'b1, 3'd0, 32'h1000, 32'h000000FF, 1'b1, 32'd0, 1, "sb_1000_err");
        run(1'b1, 3'd2, 32'h8000_0000, 32'h1, 1'b1, 32'd0, 1, "sw_high_err");
        run(1'b0, 3'd3, 32'h000, 32'd0, 1'b1, 32'd0, 1, "f3_3_err");
        run(1'b0, 3'd6, 32'h000, 32'd0, 1'b1, 32'd0, 1, "f3_6_err");
        run(1'b1, 3'd5, 32'h000, 32'h0000FFFF, 1'b1, 32'd0, 1, "shu_err");
        chk("err_no_write", 32'(wr_cnt), 32'(wr_snap));

        // Misaligned halfword load at 0x031
        run(1'b1, 3'd0, 32'h031, 32'h00000034, 1'b0, 32'd0, 2, "sb_031");
        run(1'b1, 3'd0, 32'h032, 32'h00000092, 1'b0, 32'd0, 2, "sb_032");
`ifdef LSU_MISALIGN_TRAP_EN
        run(1'b0, 3'd1, 32'h031, 32'd0, 1'b1, 32'd0, 1, "lh_031");
`else
        run(1'b0, 3'd1, 32'h031, 32'd0, 1'b0, 32'hFFFF9234, 4, "lh_031");
`endif

        // Reset during the second ACCESS cycle of a word store
        do_req(1'b1, 3'd2, 32'h040, 32'h11223344, 1'b0, 1'b0, 32'd0, 0, "sw_040_rst");
        @(posedge clock); #1;
        reset_n = 1'b0;
        #1;
        chk("rst_mid_wren", {31'd0, ram_wren}, 32'd0);
        @(posedge clock); #1;
        reset_n = 1'b1;
        repeat (8) @(posedge clock);
        #1;
        chk("rst_mid_ready", {31'd0, req_ready}, 32'd1);
        chk("rst_mid_mem", {mem[12'h043], mem[12'h042], mem[12'h041], mem[12'h040]}, 32'h00000044);
        run(1'b0, 3'd2, 32'h040, 32'd0, 1'b0, 32'h00000044, 6, "lw_040");

        #1;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rv32i_lsu_byteseq.md
# rv32i_lsu_byteseq

Load/store sequencer between the RV32I execute stage and the byte-wide 4 KB data RAM (8-bit data, 12-bit address, registered read, 1-cycle read latency, write-first). It accepts one 32-bit load or store request at a time and splits it into 1, 2 or 4 consecutive little-endian byte accesses. For loads it reassembles the bytes and sign- or zero-extends them. It returns a single-cycle response carrying the read data or an error flag.

## Interface
- `AWIDTH`, 12, RAM byte-address width; addressable range 0 to 2^AWIDTH-1.
- `clock` in 1: sole clock, rising edge.
- `reset_n` in 1: reset, asynchronous, active-low.
- `req_valid` in 1: request present.
- `req_ready` out 1: request can be accepted; high only in IDLE.
- `req_we` in 1: 1 = store, 0 = load.
- `req_funct3` in 3: RV32I funct3.
  - Loads: 0=LB, 1=LH, 2=LW, 4=LBU, 5=LHU.
  - Stores: 0=SB, 1=SH, 2=SW.
- `req_addr` in 32: byte address.
- `req_wdata` in 32: store data; the low bytes are used.
- `resp_valid` out 1: one-cycle completion pulse; no backpressure.
- `resp_err` out 1: request rejected; qualified by `resp_valid`.
- `resp_rdata` out 32: extended load data; 0 for stores and errors.
- `ram_address` out AWIDTH: RAM byte address.
- `ram_data` out 8: RAM write byte.
- `ram_wren` out 1: RAM write enable.
- `ram_q` in 8: RAM read byte, valid the cycle after its address is driven.

## Operation
- **Accept:** a request is accepted when `req_valid && req_ready`. Its opcode, address and write data are registered.
- **Byte count n:** 1 for funct3[1:0]=0, 2 for funct3[1:0]=1, 4 for funct3[1:0]=2.
- **Error check at accept** (any condition sets `resp_err`):
  - funct3 is 3, 6 or 7;
  - funct3 is 4 or 5 with `req_we`=1;
  - `req_addr + n - 1` > 2^AWIDTH-1 (evaluated in 33-bit arithmetic);
  - misalignment, when the macro below is defined.
  - An erroring request makes no RAM access. `ram_wren` stays 0 and the state goes straight to RESP.
- **States:**
  - IDLE: `req_ready`=1.
    - Accept with no error → ACCESS.
    - Accept with error → RESP.
  - ACCESS: one byte per cycle. Index k counts 0..n-1, `ram_address` = addr[AWIDTH-1:0] + k.
    - Stores: `ram_data` = wdata[8k+7:8k] and `ram_wren`=1 in every ACCESS cycle.
    - Loads: `ram_wren`=0. The byte presented on `ram_q` in the following cycle is captured into lane k.
    - After k=n-1: loads → CAPTURE, stores → RESP.
  - CAPTURE (loads only): captures the last byte from `ram_q` → RESP.
  - RESP: `resp_valid`=1 for exactly one cycle → IDLE.
- **Load extension:**
  - LB sign-extends bit 7 and LH sign-extends bit 15.
  - LBU and LHU zero-extend.
  - LW uses all 4 bytes, little-endian (byte at the lowest address goes to bits 7:0).
- **RAM outputs outside ACCESS:** `ram_wren`=0, and `ram_address`/`ram_data` hold their last value.
- **Address wrap:** the byte address never wraps, because the range check rejects any request that would cross 2^AWIDTH-1.
- **Reset mid-operation:** the state returns to IDLE immediately and no response is issued. RAM bytes already written remain written, and no further write occurs.

## Timing
- The accept cycle is cycle 0. ACCESS occupies cycles 1..n.
- Response cycle:
  - Load: `resp_valid` in cycle n+2 (LB in cycle 3, LW in cycle 6).
  - Store: `resp_valid` in cycle n+1 (SB in cycle 2, SW in cycle 5).
  - Error: `resp_valid` in cycle 1.
- Throughput: the next request can be accepted in the cycle after RESP. Back-to-back SW requests complete once every 6 cycles.
- All outputs are driven from registers, or decoded from registered state only.
- Reset values:
  - `req_ready`=1 (state IDLE);
  - `resp_valid`, `resp_err`, `ram_wren` = 0;
  - `resp_rdata`, `ram_address`, `ram_data` = 0.
- `req_*` is sampled only in the accept cycle. It may change freely afterwards.

## Configuration
- Macro: `LSU_MISALIGN_TRAP_EN`.
- **Defined:** misaligned requests are errors, with no RAM access and response in cycle 1. Misaligned means:
  - LH/LHU/SH with addr[0]≠0;
  - LW/SW with addr[1:0]≠0.
- **Undefined:** misaligned requests are performed byte by byte as normal, with the same latency as aligned ones. Only the range and funct3 checks apply.

## Test plan
- **SW then LW:** SW addr 0x010, wdata 0xA1B2C3D4 → RAM bytes [0x010..0x013] = D4,C3,B2,A1, and `resp_valid` in cycle 5. LW addr 0x010 → `resp_rdata`=0xA1B2C3D4 in cycle 6, `resp_err`=0.
- **Byte extension:** SB addr 0x7FF, wdata 0x00000080 → written. LB at 0x7FF returns 0xFFFFFF80; LBU at 0x7FF returns 0x00000080.
- **Halfword extension:** SH addr 0x020, wdata 0x12348001 → LH returns 0xFFFF8001 and LHU returns 0x00008001.
- **Range error:** LW addr 0xFFE → `resp_err`=1, `resp_rdata`=0 in cycle 1, `ram_wren` never high. SB at 0x1000 → same error behaviour.
- **Misaligned LH at 0x031:**
  - With the macro: `resp_err`=1 in cycle 1.
  - Without the macro: data is assembled from bytes 0x031 (low) and 0x032 (high), in cycle 4.
- **Reset mid-store:** SW addr 0x040 with `reset_n` pulsed low during the 2nd ACCESS cycle → only byte 0x040 is written, no `resp_valid`, `req_ready`=1 after release.
